// File: rtl/actuator_arbiter_pkg.sv
// Shared types for the actuator arbiter: the 2-bit state encoding that also
// appears on the out_state debug port.
package actuator_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_COOL = 2'b10
   } arb_state_e;

endpackage

// File: rtl/actuator_arbiter_second_ticker.sv
// Prescaler that emits a 1-cycle tick every TICKS_PER_SEC clocks; clr restarts
// the second from count 0 on the next edge.
module actuator_arbiter_second_ticker #(
   parameter int TICKS_PER_SEC = 50_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int PW = $clog2(TICKS_PER_SEC);
   localparam logic [PW-1:0] LAST = PW'(TICKS_PER_SEC - 1);

   logic [PW-1:0] count_q;

   assign tick = (count_q == LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (clr || tick) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + PW'(1);
      end
   end

endmodule

// File: rtl/actuator_arbiter.sv
// Time-sliced owner of one actuator: requester 0 has fixed priority and may
// preempt, requesters 1..N_REQ-1 rotate, every release is followed by a cooldown.
module actuator_arbiter
   import actuator_arbiter_pkg::*;
#(
   parameter int N_REQ         = 3,
   parameter int TICKS_PER_SEC = 50_000_000,
   parameter int DUR_W         = 4,
   parameter int COOLDOWN_SEC  = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ*DUR_W-1:0]   dur,
   output logic [N_REQ-1:0]         grant,
   output logic [N_REQ-1:0]         done,
   output logic                     busy,
   output logic [1:0]               out_state
);

   localparam int IW = $clog2(N_REQ);
   localparam int CW = (COOLDOWN_SEC > 1) ? $clog2(COOLDOWN_SEC) : 1;
   localparam logic [N_REQ-1:0] ONE = N_REQ'(1);
   localparam arb_state_e AFTER_RUN = (COOLDOWN_SEC == 0) ? ST_IDLE : ST_COOL;

   arb_state_e       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
   logic             busy_q;
   logic [IW-1:0]    win_q, win_d, ptr_q, ptr_d, ptr_adv;
   logic [IW-1:0]    sel, sel_hi, sel_lo;
   logic             found_hi, found_lo;
   logic [DUR_W-1:0] rem_q, rem_d, sel_dur;
   logic [CW-1:0]    cool_q, cool_d;
   logic             clr, tick, held, completion;

   function automatic logic [DUR_W-1:0] load_dur(input logic [DUR_W-1:0] d);
      return (d == '0) ? DUR_W'(1) : d;
   endfunction

   actuator_arbiter_second_ticker #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_second_ticker (
      .clk  (clk),
      .reset(reset),
      .clr  (clr),
      .tick (tick)
   );

   // Rotating scan over 1..N_REQ-1: lowest set index at/above the pointer,
   // else lowest set index below it. Requester 0 overrides the scan.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      sel_hi   = '0;
      sel_lo   = '0;
      for (int i = N_REQ - 1; i >= 1; i--) begin
         if (req[i]) begin
            if (i >= int'(ptr_q)) begin
               found_hi = 1'b1;
               sel_hi   = IW'(i);
            end else begin
               found_lo = 1'b1;
               sel_lo   = IW'(i);
            end
         end
      end
      if (req[0])        sel = '0;
      else if (found_hi) sel = sel_hi;
      else               sel = sel_lo;
      sel_dur = dur[DUR_W-1:0];
      for (int i = 1; i < N_REQ; i++) begin
         if (sel == IW'(i)) sel_dur = dur[i*DUR_W +: DUR_W];
      end
   end

   // A requester holds req high until it sees done or gives up; grant is the
   // ownership handshake, and req dropping while granted is a withdrawal.
   assign held       = |(req & grant_q);
   assign completion = tick && (rem_q == DUR_W'(1));
   assign ptr_adv    = (win_q == '0)              ? ptr_q :
                       (win_q == IW'(N_REQ - 1))  ? IW'(1) : win_q + IW'(1);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      done_d  = '0;
      win_d   = win_q;
      ptr_d   = ptr_q;
      rem_d   = rem_q;
      cool_d  = cool_q;
      clr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            clr     = 1'b1;
            grant_d = '0;
            if (|req) begin
               win_d   = sel;
               rem_d   = load_dur(sel_dur);
               grant_d = ONE << sel;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!held) begin
               grant_d = '0;
               clr     = 1'b1;
               ptr_d   = ptr_adv;
               cool_d  = '0;
               state_d = AFTER_RUN;
            end else if (completion) begin
               done_d  = grant_q;
               grant_d = '0;
               clr     = 1'b1;
               ptr_d   = ptr_adv;
               cool_d  = '0;
               state_d = AFTER_RUN;
            end else if (req[0] && (win_q != '0)) begin
               // Preempted requester keeps the pointer so it is served next.
               win_d   = '0;
               rem_d   = load_dur(dur[DUR_W-1:0]);
               grant_d = ONE;
               clr     = 1'b1;
            end else if (tick) begin
               rem_d = rem_q - DUR_W'(1);
            end
         end
         ST_COOL: begin
            grant_d = '0;
            if (tick) begin
               if (cool_q == CW'(COOLDOWN_SEC - 1)) state_d = ST_IDLE;
               else                                  cool_d  = cool_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         done_q  <= '0;
         busy_q  <= 1'b0;
         win_q   <= '0;
         ptr_q   <= IW'(1);
         rem_q   <= '0;
         cool_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         busy_q  <= (state_d != ST_IDLE);
         win_q   <= win_d;
         ptr_q   <= ptr_d;
         rem_q   <= rem_d;
         cool_q  <= cool_d;
      end
   end

   assign grant     = grant_q;
   assign done      = done_q;
   assign busy      = busy_q;
   assign out_state = state_q;

endmodule

// File: tb/tb_actuator_arbiter.sv
// Directed bench for actuator_arbiter: expected output events (with the cycle
// gap since the previous event) are queued by the driver and popped by a monitor.
module tb_actuator_arbiter;

   localparam int N_REQ = 3;
   localparam int DUR_W = 4;
   localparam int ANY   = 255;

   logic                   clk;
   logic                   reset;
   logic [N_REQ-1:0]       req;
   logic [N_REQ*DUR_W-1:0] dur;
   logic [N_REQ-1:0]       grant;
   logic [N_REQ-1:0]       done;
   logic                   busy;
   logic [1:0]             out_state;

   int n_checks = 0;
   int n_pass   = 0;

   logic [16:0] exp_q[$];
   string       name_q[$];

   logic        mon_en = 1'b0;
   logic        multi_hot = 1'b0;
   logic [8:0]  cur;
   logic [8:0]  prev = '0;
   int          gap = 0;
   logic [16:0] e;
   string       nm;

   actuator_arbiter #(
      .N_REQ(N_REQ), .TICKS_PER_SEC(4), .DUR_W(DUR_W), .COOLDOWN_SEC(1)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .dur(dur),
      .grant(grant), .done(done), .busy(busy), .out_state(out_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      step(1);
      reset = 1'b0;
      step(1);
      reset = 1'b1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) $display("FAIL %s: got %0h expected %0h", name, act, want);
      else              n_pass++;
   endtask

   task automatic expect_ev(input string name, input int g, input logic [2:0] d,
                            input logic [2:0] gr, input logic b, input logic [1:0] s);
      exp_q.push_back({8'(g), d, gr, b, s});
      name_q.push_back(name);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (mon_en) begin
         cur = {done, grant, busy, out_state};
         if ($countones(grant) > 1) multi_hot = 1'b1;
         if (gap < 254) gap = gap + 1;
         if (cur !== prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_event: got gap=%0d done/grant/busy/state=%b, expected no event", gap, cur);
            end else begin
               e  = exp_q.pop_front();
               nm = name_q.pop_front();
               if ((e[8:0] !== cur) || ((int'(e[16:9]) != ANY) && (int'(e[16:9]) != gap)))
                  $display("FAIL %s: got gap=%0d done/grant/busy/state=%b, expected gap=%0d %b",
                           nm, gap, cur, e[16:9], e[8:0]);
               else
                  n_pass++;
            end
            prev = cur;
            gap  = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1;
      req   = '0;
      dur   = '0;
      #1 reset = 1'b0;
      #1;
      check("reset_grant", 32'(grant), 0);
      check("reset_done", 32'(done), 0);
      check("reset_busy", 32'(busy), 0);
      check("reset_state", 32'(out_state), 0);
      @(posedge clk);
      #2 reset = 1'b1;
      mon_en = 1'b1;

      // 1: single 3 s hold, dur change mid-run ignored
      expect_ev("t1_grant1", ANY, 3'b000, 3'b010, 1'b1, 2'b01);
      expect_ev("t1_done1",  12,  3'b010, 3'b000, 1'b1, 2'b10);
      expect_ev("t1_cool",   1,   3'b000, 3'b000, 1'b1, 2'b10);
      expect_ev("t1_idle",   3,   3'b000, 3'b000, 1'b0, 2'b00);
      step(1);
      dur = {4'd0, 4'd3, 4'd0};
      req = 3'b010;
      step(3);
      dur = {4'd0, 4'd1, 4'd0};
      step(10);
      req = 3'b000;
      step(8);

      // 2: round robin between 1 and 2
      do_reset();
      for (int k = 0; k < 4; k++) begin
         expect_ev("t2_grant", (k == 0) ? ANY : 1, 3'b000, (k % 2 == 0) ? 3'b010 : 3'b100, 1'b1, 2'b01);
         expect_ev("t2_done",  4, (k % 2 == 0) ? 3'b010 : 3'b100, 3'b000, 1'b1, 2'b10);
         expect_ev("t2_cool",  1, 3'b000, 3'b000, 1'b1, 2'b10);
         expect_ev("t2_idle",  3, 3'b000, 3'b000, 1'b0, 2'b00);
      end
      step(1);
      dur = {4'd1, 4'd1, 4'd0};
      req = 3'b110;
      step(32);
      req = 3'b000;
      step(8);

      // 3: preemption by requester 0, preempted requester served next
      do_reset();
      expect_ev("t3_grant1",   ANY, 3'b000, 3'b010, 1'b1, 2'b01);
      expect_ev("t3_preempt",  6,   3'b000, 3'b001, 1'b1, 2'b01);
      expect_ev("t3_done0",    8,   3'b001, 3'b000, 1'b1, 2'b10);
      expect_ev("t3_cool",     1,   3'b000, 3'b000, 1'b1, 2'b10);
      expect_ev("t3_idle",     3,   3'b000, 3'b000, 1'b0, 2'b00);
      expect_ev("t3_regrant1", 1,   3'b000, 3'b010, 1'b1, 2'b01);
      expect_ev("t3_done1",    4,   3'b010, 3'b000, 1'b1, 2'b10);
      expect_ev("t3_cool2",    1,   3'b000, 3'b000, 1'b1, 2'b10);
      expect_ev("t3_idle2",    3,   3'b000, 3'b000, 1'b0, 2'b00);
      step(1);
      dur = {4'd0, 4'd5, 4'd2};
      req = 3'b010;
      step(6);
      req = 3'b011;
      step(9);
      req = 3'b010;
      dur = {4'd0, 4'd1, 4'd2};
      step(9);
      req = 3'b000;
      step(8);

      // 4: withdrawal, no done, full cooldown
      do_reset();
      expect_ev("t4_grant2",   ANY, 3'b000, 3'b100, 1'b1, 2'b01);
      expect_ev("t4_withdraw", 3,   3'b000, 3'b000, 1'b1, 2'b10);
      expect_ev("t4_idle",     4,   3'b000, 3'b000, 1'b0, 2'b00);
      step(1);
      dur = {4'd4, 4'd0, 4'd0};
      req = 3'b100;
      step(3);
      req = 3'b000;
      step(8);

      // 5: zero duration treated as one second
      do_reset();
      expect_ev("t5_grant1", ANY, 3'b000, 3'b010, 1'b1, 2'b01);
      expect_ev("t5_done1",  4,   3'b010, 3'b000, 1'b1, 2'b10);
      expect_ev("t5_cool",   1,   3'b000, 3'b000, 1'b1, 2'b10);
      expect_ev("t5_idle",   3,   3'b000, 3'b000, 1'b0, 2'b00);
      step(1);
      dur = '0;
      req = 3'b010;
      step(5);
      req = 3'b000;
      step(8);

      // 6: pointer left at 2, reset mid-run restores pointer 1
      expect_ev("t6_grant2",   ANY, 3'b000, 3'b100, 1'b1, 2'b01);
      expect_ev("t6_reset",    3,   3'b000, 3'b000, 1'b0, 2'b00);
      expect_ev("t6_grant1",   2,   3'b000, 3'b010, 1'b1, 2'b01);
      expect_ev("t6_withdraw", 1,   3'b000, 3'b000, 1'b1, 2'b10);
      expect_ev("t6_idle",     4,   3'b000, 3'b000, 1'b0, 2'b00);
      step(1);
      dur = {4'd3, 4'd3, 4'd0};
      req = 3'b110;
      step(4);
      reset = 1'b0;
      #1;
      check("t6_async_grant", 32'(grant), 0);
      check("t6_async_busy", 32'(busy), 0);
      check("t6_async_state", 32'(out_state), 0);
      step(1);
      reset = 1'b1;
      step(1);
      req = 3'b000;
      step(8);

      // 7: completion tick coincides with req[0] rise
      do_reset();
      expect_ev("t7_grant1", ANY, 3'b000, 3'b010, 1'b1, 2'b01);
      expect_ev("t7_done1",  4,   3'b010, 3'b000, 1'b1, 2'b10);
      expect_ev("t7_cool",   1,   3'b000, 3'b000, 1'b1, 2'b10);
      expect_ev("t7_idle",   3,   3'b000, 3'b000, 1'b0, 2'b00);
      expect_ev("t7_grant0", 1,   3'b000, 3'b001, 1'b1, 2'b01);
      expect_ev("t7_done0",  4,   3'b001, 3'b000, 1'b1, 2'b10);
      expect_ev("t7_cool2",  1,   3'b000, 3'b000, 1'b1, 2'b10);
      expect_ev("t7_idle2",  3,   3'b000, 3'b000, 1'b0, 2'b00);
      step(1);
      dur = {4'd0, 4'd1, 4'd1};
      req = 3'b010;
      step(4);
      req = 3'b011;
      step(1);
      req = 3'b001;
      step(9);
      req = 3'b000;
      step(8);

      // ---------------- final report ----------------
      mon_en = 1'b0;
      check("events_outstanding", 32'(exp_q.size()), 0);
      check("grant_multi_hot", 32'(multi_hot), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
